// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared FSM encodings, default sizes and the round-robin pick
//               function for the serial transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_N_REQ_DEF  = 4;
    localparam int c_DATA_W_DEF = 8;
    localparam int c_MAX_REQ    = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } rr_pick_t;

    // Search starts one past the last winner so that winner has lowest priority.
    function automatic rr_pick_t rr_pick(input logic [c_MAX_REQ-1:0] req,
                                         input int unsigned ptr,
                                         input int unsigned n);
        rr_pick_t    r;
        int unsigned cand;
        logic [2:0]  c3;
        r.found = 1'b0;
        r.idx   = '0;
        for (int unsigned k = 1; k <= c_MAX_REQ; k++) begin
            cand = (ptr + k) % n;
            c3   = cand[2:0];
            if (k <= n && !r.found && req[c3]) begin
                r.found = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_sched_if
// Description : Requester bus and serial output bundle of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_tx_sched_if #(
    parameter int N_REQ  = spi_pkg::c_N_REQ_DEF,
    parameter int DATA_W = spi_pkg::c_DATA_W_DEF,
    parameter int IDX_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] data;
    logic [N_REQ-1:0]        ack;
    logic                    ser_bit;   // serial data, MSB first
    logic                    valid;
    logic [IDX_W-1:0]        sel;
    logic                    busy;
    logic                    done;

    modport master (
        output req, data,
        input  ack, ser_bit, valid, sel, busy, done
    );

    modport slave (
        input  req, data,
        output ack, ser_bit, valid, sel, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_reg
// Description : Parallel-load, shift-left register exposing its MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_shift,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_q_msb
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {r_q[WIDTH-2:0], 1'b0};
        end
    end

    assign o_q_msb = r_q[WIDTH-1];
endmodule
`default_nettype wire

// File: rtl/spi_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_sched
// Description : Round-robin scheduler sharing one MSB-first bit-serial
//               transmitter between N_REQ byte requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_sched
    import spi_pkg::*;
#(
    parameter int N_REQ  = c_N_REQ_DEF,
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int IDX_W  = $clog2(N_REQ)
) (
    input wire logic       clk,
    input wire logic       rst,
    spi_tx_sched_if.slave  bus
);
    localparam int c_CNT_W = $clog2(DATA_W) + 1;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_sel;
    logic [N_REQ-1:0]     r_ack;
    logic                 r_bit;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;

    logic [DATA_W-1:0]    w_bytes [N_REQ];
    rr_pick_t             w_pick;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [DATA_W-1:0]    w_grant_byte;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_sr_msb;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_bytes[gi] = bus.data[gi*DATA_W +: DATA_W];
    end

    assign w_pick       = rr_pick(c_MAX_REQ'(bus.req), 32'(r_ptr), N_REQ);
    assign w_grant_idx  = IDX_W'(w_pick.idx);
    assign w_grant_byte = w_bytes[w_grant_idx];
    assign w_load       = (r_state == ST_IDLE) && w_pick.found;
    assign w_shift      = (r_state == ST_SHIFT) && (r_cnt != '0);

    // The MSB leaves directly from the grant edge, so the register is loaded
    // pre-shifted and its MSB is always the next bit due on the line.
    spi_shift_reg #(
        .WIDTH (DATA_W)
    ) u_shift_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  ({w_grant_byte[DATA_W-2:0], 1'b0}),
        .o_q_msb (w_sr_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= IDX_W'(N_REQ - 1);
            r_sel   <= '0;
            r_ack   <= '0;
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bit   <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    if (w_pick.found) begin
                        r_ack   <= N_REQ'(1) << w_grant_idx;
                        r_sel   <= w_grant_idx;
                        r_ptr   <= w_grant_idx;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_bit   <= w_grant_byte[DATA_W-1];
                        r_cnt   <= c_CNT_W'(DATA_W - 1);
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_valid <= 1'b0;
                        r_bit   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_bit <= w_sr_msb;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack     = r_ack;
    assign bus.ser_bit = r_bit;
    assign bus.valid   = r_valid;
    assign bus.sel     = r_sel;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule
`default_nettype wire
